// File: rtl/ntt_pkg.sv
// Shared types for the radix-2 NTT sequencer:
// state encoding and butterfly address helper.
package ntt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_e;

  localparam int MAX_LOG_N = 12;

  typedef struct packed {
    logic [MAX_LOG_N-1:0] a;
    logic [MAX_LOG_N-1:0] b;
    logic [MAX_LOG_N-1:0] tw;
  } bfly_addr_t;

  // Butterfly j of stage s: upper/lower leg
  // addresses and twiddle index.
  function automatic bfly_addr_t bfly_addr(
    input int unsigned s,
    input int unsigned j,
    input int unsigned log_n
  );
    int unsigned half;
    int unsigned grp;
    int unsigned k;
    int unsigned a;
    bfly_addr_t  r;
    half = 32'd1 << s;
    grp  = j >> s;
    k    = j & (half - 32'd1);
    a    = (grp << (s + 32'd1)) + k;
    r.a  = MAX_LOG_N'(a);
    r.b  = MAX_LOG_N'(a + half);
    r.tw = MAX_LOG_N'(k << (log_n - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Resettable DEPTH-stage shift register.
// Ports: clk, rst (async high), d_i in, q_o tail.
module ntt_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_radix2_ctrl.sv
// Radix-2 in-place NTT sequencer: issues
// butterfly read/twiddle addresses stage by
// stage, drains the datapath between stages
// and delays addresses for write-back.
// Ports: clk, rst (async high), start, hold
// in; busy, done, stage, rd_*, tw_addr,
// wr_* out (all registered).
module ntt_radix2_ctrl
  import ntt_pkg::*;
#(
  parameter int LOG_N    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG_N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG_N-1:0]         rd_addr_a,
  output logic [LOG_N-1:0]         rd_addr_b,
  output logic [LOG_N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG_N-1:0]         wr_addr_a,
  output logic [LOG_N-1:0]         wr_addr_b
);

  localparam int SW = $clog2(LOG_N);
  localparam int JW = LOG_N - 1;
  localparam int DW = 2 * LOG_N + 1;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST =
    SW'(LOG_N - 1);
  localparam logic [3:0] DRAIN_INIT =
    4'(PIPE_LAT - 1);

  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [JW-1:0]   j_q;
  logic [3:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  logic [LOG_N-1:0] rd_a_q;
  logic [LOG_N-1:0] rd_b_q;
  logic [JW-1:0]   tw_q;

  bfly_addr_t       addr_d;
  logic [LOG_N-1:0] rd_a_d;
  logic [LOG_N-1:0] rd_b_d;
  logic [JW-1:0]    tw_d;
  logic             unused_addr_bits;

  always_comb begin
    addr_d = bfly_addr(32'(s_q), 32'(j_q),
                       32'(LOG_N));
    rd_a_d = addr_d.a[LOG_N-1:0];
    rd_b_d = addr_d.b[LOG_N-1:0];
    tw_d   = addr_d.tw[JW-1:0];
  end

  assign unused_addr_bits = ^addr_d;

  // busy lags state by one edge so it rises
  // together with the first issue strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      busy_q  <= (state_q != S_IDLE);
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            s_q     <= '0;
            j_q     <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            rd_en_q <= 1'b1;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            j_q     <= j_q + JW'(1);
            if (j_q == J_LAST) begin
              cnt_q   <= DRAIN_INIT;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (s_q == S_LAST) begin
            state_q <= S_DONE;
          end else begin
            s_q     <= s_q + SW'(1);
            j_q     <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic [DW-1:0] wb_d;
  logic [DW-1:0] wb_q;

  assign wb_d = {rd_en_q, rd_a_q, rd_b_q};

  ntt_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE_LAT)
  ) u_wb_dly (
    .clk (clk),
    .rst (rst),
    .d_i (wb_d),
    .q_o (wb_q)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = s_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wb_q[DW-1];
  assign wr_addr_a = wb_q[2*LOG_N-1:LOG_N];
  assign wr_addr_b = wb_q[LOG_N-1:0];

endmodule

// File: tb/tb_ntt_radix2_ctrl.sv
// Bench for ntt_radix2_ctrl: small config
// vs. timeline model, large config scoreboard.
module tb_ntt_radix2_ctrl;

  localparam int LN  = 3;
  localparam int P   = 2;
  localparam int N   = 8;
  localparam int NC  = 64;
  localparam int LN2 = 8;
  localparam int N2  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start1 = 1'b0;
  logic       hold1  = 1'b0;
  logic       busy1, done1, rd1, wr1;
  logic [1:0] st1;
  logic [2:0] ra1, rb1, wa1, wb1;
  logic [1:0] tw1;

  logic       start2 = 1'b0;
  logic       hold2  = 1'b0;
  logic       busy2, done2, rd2, wr2;
  logic [2:0] st2;
  logic [7:0] ra2, rb2, wa2, wb2;
  logic [6:0] tw2;

  always #5 clk = ~clk;

  ntt_radix2_ctrl #(
    .LOG_N (LN),
    .PIPE_LAT (P)
  ) dut1 (
    .clk (clk), .rst (rst),
    .start (start1), .hold (hold1),
    .busy (busy1), .done (done1),
    .stage (st1), .rd_en (rd1),
    .rd_addr_a (ra1), .rd_addr_b (rb1),
    .tw_addr (tw1), .wr_en (wr1),
    .wr_addr_a (wa1), .wr_addr_b (wb1)
  );

  ntt_radix2_ctrl #(
    .LOG_N (LN2),
    .PIPE_LAT (4)
  ) dut2 (
    .clk (clk), .rst (rst),
    .start (start2), .hold (hold2),
    .busy (busy2), .done (done2),
    .stage (st2), .rd_en (rd2),
    .rd_addr_a (ra2), .rd_addr_b (rb2),
    .tw_addr (tw2), .wr_en (wr2),
    .wr_addr_a (wa2), .wr_addr_b (wb2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input int c,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               nm, c, act, exp);
    end
  endtask

  bit start_v [NC];
  bit hold_v  [NC];

  int o_rd[NC], o_a[NC], o_b[NC], o_tw[NC];
  int o_st[NC], o_wr[NC], o_wa[NC], o_wb[NC];
  int o_done[NC], o_busy[NC];

  int e_rd[NC], e_a[NC], e_b[NC], e_tw[NC];
  int e_st[NC], e_wr[NC], e_wa[NC], e_wb[NC];
  int e_done[NC], e_busy[NC];

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      start_v[c] = 1'b0;
      hold_v[c]  = 1'b0;
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0;
      e_tw[c] = 0; e_st[c] = 0; e_wr[c] = 0;
      e_wa[c] = 0; e_wb[c] = 0;
      e_done[c] = 0; e_busy[c] = 0;
    end
  endtask

  // Timeline of one transform started in
  // cycle t0; nothing after cycle cut counts.
  task automatic model_run(input int t0,
                           input int cut);
    int cur;
    int half;
    int a;
    cur = t0;
    for (int s = 0; s < LN; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int k = 0; k < half; k++) begin
          cur++;
          while (cur < NC && hold_v[cur]) cur++;
          a = g * 2 * half + k;
          if (cur <= cut) begin
            e_rd[cur] = 1;
            e_a[cur]  = a;
            e_b[cur]  = a + half;
            e_tw[cur] = k * (N / (2 * half));
            e_st[cur] = s;
          end
          if (cur + P <= cut) begin
            e_wr[cur + P] = 1;
            e_wa[cur + P] = a;
            e_wb[cur + P] = a + half;
          end
        end
      end
      cur += P;
    end
    if (cur + 1 <= cut) e_done[cur + 1] = 1;
    for (int c = t0 + 1; c <= cur + 1; c++) begin
      if (c <= cut) e_busy[c] = 1;
    end
  endtask

  // Applies the stimulus arrays; optional
  // async reset asserted mid-cycle rst_on,
  // released mid-cycle rst_off.
  task automatic run(input int rst_on,
                     input int rst_off);
    for (int c = 0; c < NC; c++) begin
      start1 = start_v[c];
      hold1  = hold_v[c];
      @(posedge clk);
      #1;
      o_rd[c] = int'(rd1);
      o_a[c]  = int'(ra1);
      o_b[c]  = int'(rb1);
      o_tw[c] = int'(tw1);
      o_st[c] = int'(st1);
      o_wr[c] = int'(wr1);
      o_wa[c] = int'(wa1);
      o_wb[c] = int'(wb1);
      o_done[c] = int'(done1);
      o_busy[c] = int'(busy1);
      if (c == rst_on) begin
        #1 rst = 1'b1;
        #1;
        check("rst_async_zero", c,
              longint'({busy1, done1, st1, rd1,
                        ra1, rb1, tw1, wr1,
                        wa1, wb1}), 0);
      end
      if (c == rst_off) begin
        #1 rst = 1'b0;
      end
    end
    start1 = 1'b0;
    hold1  = 1'b0;
  endtask

  task automatic compare_run(input string tag);
    for (int c = 0; c < NC; c++) begin
      check({tag, "_rd_en"}, c, o_rd[c], e_rd[c]);
      check({tag, "_wr_en"}, c, o_wr[c], e_wr[c]);
      check({tag, "_done"}, c, o_done[c], e_done[c]);
      check({tag, "_busy"}, c, o_busy[c], e_busy[c]);
      if (e_rd[c] != 0) begin
        check({tag, "_rd_a"}, c, o_a[c], e_a[c]);
        check({tag, "_rd_b"}, c, o_b[c], e_b[c]);
        check({tag, "_tw"}, c, o_tw[c], e_tw[c]);
        check({tag, "_stage"}, c, o_st[c], e_st[c]);
      end
      if (e_wr[c] != 0) begin
        check({tag, "_wr_a"}, c, o_wa[c], e_wa[c]);
        check({tag, "_wr_b"}, c, o_wb[c], e_wb[c]);
      end
    end
  endtask

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } vec_t;

  typedef struct {
    int s;
    int a;
    int b;
    int tw;
  } big_t;

  vec_t tbl[12];
  big_t bq[$];
  bit   seen[LN2][N2];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int idx;
    int done_c;
    int wr_cnt;
    int seen_cnt;
    int half;

    tbl[0]  = '{1, 0, 1, 0};
    tbl[1]  = '{2, 2, 3, 0};
    tbl[2]  = '{3, 4, 5, 0};
    tbl[3]  = '{4, 6, 7, 0};
    tbl[4]  = '{7, 0, 2, 0};
    tbl[5]  = '{8, 1, 3, 2};
    tbl[6]  = '{9, 4, 6, 0};
    tbl[7]  = '{10, 5, 7, 2};
    tbl[8]  = '{13, 0, 4, 0};
    tbl[9]  = '{14, 1, 5, 1};
    tbl[10] = '{15, 2, 6, 2};
    tbl[11] = '{16, 3, 7, 3};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", -1,
          longint'({busy1, done1, st1, rd1, ra1,
                    rb1, tw1, wr1, wa1, wb1}), 0);
    check("reset_dut2", -1,
          longint'({busy2, done2, st2, rd2, ra2,
                    rb2, tw2, wr2, wa2, wb2}), 0);
    rst = 1'b0;

    // Plain run
    clear_stim();
    start_v[0] = 1'b1;
    run(-1, -1);
    model_clear();
    model_run(0, NC - 1);
    compare_run("t1");
    for (int i = 0; i < 12; i++) begin
      check("t1_vec", tbl[i].cyc,
            o_rd[tbl[i].cyc] * 4096 +
            o_a[tbl[i].cyc] * 256 +
            o_b[tbl[i].cyc] * 16 +
            o_tw[tbl[i].cyc],
            4096 + tbl[i].a * 256 +
            tbl[i].b * 16 + tbl[i].tw);
    end
    check("t1_done19", 19, o_done[19], 1);
    check("t1_wr3_addr", 3,
          o_wa[3] * 16 + o_wb[3], 1);

    // Back-pressure in cycles 2-3
    clear_stim();
    start_v[0] = 1'b1;
    hold_v[2]  = 1'b1;
    hold_v[3]  = 1'b1;
    run(-1, -1);
    model_clear();
    model_run(0, NC - 1);
    compare_run("t2");
    check("t2_issue4", 4,
          o_rd[4] * 4096 + o_a[4] * 256 +
          o_b[4] * 16 + o_tw[4],
          4096 + 2 * 256 + 3 * 16);
    check("t2_done21", 21, o_done[21], 1);

    // Async reset mid-run, then restart
    clear_stim();
    start_v[0]  = 1'b1;
    start_v[12] = 1'b1;
    run(8, 10);
    model_clear();
    model_run(0, 8);
    model_run(12, NC - 1);
    compare_run("t3");
    check("t3_done31", 31, o_done[31], 1);

    // start re-pulsed while busy / in DONE
    clear_stim();
    start_v[0]  = 1'b1;
    start_v[5]  = 1'b1;
    start_v[19] = 1'b1;
    run(-1, -1);
    model_clear();
    model_run(0, NC - 1);
    compare_run("t4");

    // Random hold and stray start pulses
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      start_v[0] = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        hold_v[c] = ($urandom_range(0, 3) == 0);
      end
      for (int c = 2; c <= 15; c++) begin
        start_v[c] = ($urandom_range(0, 5) == 0);
      end
      run(-1, -1);
      model_clear();
      model_run(0, NC - 1);
      compare_run("rnd");
    end

    // Full-size transform scoreboard
    for (int s = 0; s < LN2; s++) begin
      half = 1 << s;
      for (int g = 0; g < N2 / (2 * half); g++) begin
        for (int k = 0; k < half; k++) begin
          bq.push_back('{s, g * 2 * half + k,
                         g * 2 * half + k + half,
                         k * (N2 / (2 * half))});
        end
      end
    end
    idx = 0;
    done_c = -1;
    wr_cnt = 0;
    for (int c = 0; c < 1200; c++) begin
      start2 = (c == 0);
      @(posedge clk);
      #1;
      if (rd2) begin
        if (idx < bq.size()) begin
          check("big_issue", c,
                (longint'(st2) << 24) |
                (longint'(ra2) << 16) |
                (longint'(rb2) << 8) |
                longint'(tw2),
                (longint'(bq[idx].s) << 24) |
                (longint'(bq[idx].a) << 16) |
                (longint'(bq[idx].b) << 8) |
                longint'(bq[idx].tw));
        end else begin
          check("big_extra_issue", c, 1, 0);
        end
        check("big_touch_a", c,
              longint'(seen[st2][ra2]), 0);
        seen[st2][ra2] = 1'b1;
        check("big_touch_b", c,
              longint'(seen[st2][rb2]), 0);
        seen[st2][rb2] = 1'b1;
        idx++;
      end
      if (wr2) wr_cnt++;
      if (done2 && done_c < 0) done_c = c;
    end
    start2 = 1'b0;
    seen_cnt = 0;
    for (int s = 0; s < LN2; s++) begin
      for (int a = 0; a < N2; a++) begin
        seen_cnt += int'(seen[s][a]);
      end
    end
    check("big_issue_count", idx, idx, 1024);
    check("big_wr_count", wr_cnt, wr_cnt, 1024);
    check("big_coverage", 0, seen_cnt, LN2 * N2);
    check("big_done_cycle", done_c, done_c, 1057);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_radix2_ctrl.md
Name: ntt_radix2_ctrl

Overview:
- Sequencer for the radix-2 NTT datapath: mod-multiply stage feeding the butterfly stage.
- Walks all LOG_N stages of an in-place Cooley-Tukey transform over an N = 2^LOG_N coefficient memory.
- Per butterfly it issues the operand read-address pair and the twiddle-ROM address.
- Delays matching write-back addresses by the datapath latency, drains the pipe between stages to avoid read-after-write hazards, and signals completion.

Parameters:
- LOG_N, 8, log2 of transform length; N = 2^LOG_N, legal range 2..12.
- PIPE_LAT, 4, cycles from rd_en to valid datapath result (memory read + mult_mod + butterfly); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full transform; ignored unless IDLE.
- hold  in  1  when high, suppresses issue of the next butterfly (back-pressure); does not freeze the write-back pipe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last write-back of the last stage has retired.
- stage  out  $clog2(LOG_N)  current stage index s.
- rd_en  out  1  butterfly issue strobe.
- rd_addr_a  out  LOG_N  upper-leg operand address.
- rd_addr_b  out  LOG_N  lower-leg operand address.
- tw_addr  out  LOG_N-1  twiddle ROM index.
- wr_en  out  1  write-back strobe (rd_en delayed PIPE_LAT).
- wr_addr_a  out  LOG_N  rd_addr_a delayed PIPE_LAT.
- wr_addr_b  out  LOG_N  rd_addr_b delayed PIPE_LAT.

Behaviour:
- Reset (async, any state):
  - state returns to IDLE.
  - All counters and the delay line clear.
  - Every output is 0, including wr_en, so no write-back leaks after reset mid-operation.
- States: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 sampled at a rising edge: stage:=0, j:=0, next state ISSUE.
  - start=0: stay in IDLE.
- ISSUE, per cycle with hold=0:
  - rd_en=1; j is the butterfly counter, 0..N/2-1.
  - half = 1<<s; grp = j>>s; k = j & (half-1).
  - rd_addr_a = (grp<<(s+1)) + k.
  - rd_addr_b = rd_addr_a + half.
  - tw_addr = k<<(LOG_N-1-s).
  - j increments.
  - After j = N/2-1 is issued: next state DRAIN, drain counter := PIPE_LAT.
- ISSUE with hold=1: rd_en=0, j and addresses frozen, state unchanged.
- DRAIN:
  - Counts down PIPE_LAT cycles with rd_en=0; hold is ignored.
  - At zero, if s < LOG_N-1: s:=s+1, j:=0, next state ISSUE.
  - Otherwise: next state DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1, then IDLE.
  - start during DONE is ignored.
- Write-back delay line:
  - PIPE_LAT-deep shift register of {rd_en, rd_addr_a, rd_addr_b}.
  - Advances every cycle regardless of hold or state.
  - wr_* outputs are its tail.
- Cycle count with hold never asserted:
  - Take cycle 0 as the start-high cycle.
  - Each stage occupies N/2 ISSUE cycles plus PIPE_LAT DRAIN cycles.
  - done is high in cycle LOG_N*(N/2+PIPE_LAT)+1.
- start while busy has no effect; no queueing.
- Width rules:
  - All address arithmetic is unsigned LOG_N-bit; it never wraps for legal j and s.
  - tw_addr fits LOG_N-1 bits because k < half ≤ N/2.

Decomposition:
- Shared package ntt_pkg holds:
  - state encoding localparams (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
  - A function computing {addr_a, addr_b, tw} from (s, j, LOG_N), reused by the verification model.
- One sub-module is natural: ntt_delay_line (WIDTH, DEPTH), a resettable shift register used for the write-back path.

Test Plan:
- LOG_N=3, PIPE_LAT=2, start pulse in cycle 0, hold=0. Required issue sequence as (a,b,tw):
  - Cycles 1-4, stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Cycles 7-10, stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Cycles 13-16, stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - done=1 only in cycle 19; busy=1 in cycles 1-19.
- Same configuration, check write-back:
  - wr_en high in cycles 3-6, 9-12 and 15-18.
  - wr_addr_a/b equal the rd addresses from 2 cycles earlier.
  - No rd_en overlaps a wr_en of the same stage's earlier butterflies in DRAIN.
- Same configuration, hold=1 in cycles 2-3:
  - Second stage-0 butterfly (2,3,0) issues in cycle 4.
  - Every later event shifts by 2; done lands in cycle 21.
- Same configuration, rst asserted asynchronously in cycle 8, released in cycle 10:
  - All outputs 0 immediately, no wr_en afterwards.
  - A start in cycle 12 produces the full test-1 sequence shifted by 12.
- start re-pulsed in cycles 5 and 19 during a run: ignored, sequence identical to test 1, no second run.
- LOG_N=8, PIPE_LAT=4, one run:
  - Scoreboard with the package address function confirms all 1024 issues.
  - Each address is touched exactly once per stage.
  - done in cycle 8*(128+4)+1 = 1057.
